// File: rtl/led_scan_capture_if.sv
// led_scan_capture_if: bundle of the scan bus, readout port and status lines of led_scan_capture.
//   master (bench / driver side) drives comm, enable, LedR/G/B (active-low), rd_row, clr_err.
//   slave (capture block) drives rd_r/g/b, frame_valid, frame_count, seq_err, err_sticky, stalled.
interface led_scan_capture_if;
    logic [2:0] comm;
    logic       enable;
    logic [7:0] LedR;
    logic [7:0] LedG;
    logic [7:0] LedB;
    logic [2:0] rd_row;
    logic [7:0] rd_r;
    logic [7:0] rd_g;
    logic [7:0] rd_b;
    logic       frame_valid;
    logic [7:0] frame_count;
    logic       seq_err;
    logic       err_sticky;
    logic       clr_err;
    logic       stalled;
    modport master (
        output comm, enable, LedR, LedG, LedB, rd_row, clr_err,
        input  rd_r, rd_g, rd_b, frame_valid, frame_count, seq_err, err_sticky, stalled
    );
    modport slave (
        input  comm, enable, LedR, LedG, LedB, rd_row, clr_err,
        output rd_r, rd_g, rd_b, frame_valid, frame_count, seq_err, err_sticky, stalled
    );
endinterface

// File: rtl/led_scan_capture.sv
// led_scan_capture: rebuilds 8x8 RGB frames from a row-scan LED bus into a double-buffered image.
//   SYS_CLK, RST  : clock, synchronous active-high reset
//   bus (slave)   : scan inputs comm/enable/LedR/LedG/LedB (async, active-low columns),
//                   readout rd_row -> rd_r/rd_g/rd_b (1-cycle latency), frame_valid, frame_count,
//                   seq_err, err_sticky/clr_err, stalled
module led_scan_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 250000
) (
    input  logic SYS_CLK,
    input  logic RST,
    led_scan_capture_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic {HUNT, CAPTURE} state_t;
    // scan sample packed as {enable, comm, LedR, LedG, LedB}
    logic [27:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [7:0]    stab_q, stab_d;
    logic [TW-1:0] to_q, to_d;
    state_t        state_q, state_d;
    logic [2:0]    exp_row_q, exp_row_d;
    logic [23:0]   work_q [8];
    logic [23:0]   work_d [8];
    logic [23:0]   disp_q [8];
    logic [23:0]   disp_d [8];
    logic          commit_q, commit_d;
    logic          frame_valid_q, frame_valid_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          seq_err_q, seq_err_d;
    logic          err_sticky_q, err_sticky_d;
    logic [23:0]   rd_q, rd_d;
    logic          s_enable, cap, hit, err;
    logic [2:0]    s_comm;
    assign s_enable = sync2_q[27];
    assign s_comm   = sync2_q[26:24];
    always_comb begin
        sync1_d = {bus.enable, bus.comm, bus.LedR, bus.LedG, bus.LedB};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        stab_d  = (sync2_q != prev_q) ? 8'd0 : (stab_q == 8'hff) ? stab_q : stab_q + 8'd1;
        // stab_d is 0 only on a change and otherwise climbs by one, so equality hits once per dwell
        cap     = s_enable && (stab_d == 8'(SETTLE - 1));
        to_d    = cap ? '0 : (to_q >= TW'(TIMEOUT)) ? to_q : to_q + 1'b1;
    end
    always_comb begin
        state_d   = state_q;
        exp_row_d = exp_row_q;
        work_d    = work_q;
        commit_d  = 1'b0;
        hit       = 1'b0;
        err       = 1'b0;
        if (!s_enable) begin
            state_d = HUNT;
        end else if (cap) begin
            hit = (state_q == CAPTURE) && (s_comm == exp_row_q);
            err = (state_q == CAPTURE) && !hit;
            // an in-order row or any row 0 (fresh start or restart) is written
            if (hit || s_comm == 3'd0) begin
                work_d[s_comm] = ~sync2_q[23:0];
                exp_row_d      = s_comm + 3'd1;
                commit_d       = hit && (s_comm == 3'd7);
                state_d        = commit_d ? HUNT : CAPTURE;
            end else begin
                state_d = HUNT;
            end
        end
    end
    always_comb begin
        disp_d = disp_q;
        if (commit_q) disp_d = work_q;
        frame_valid_d = commit_q;
        frame_count_d = frame_count_q + 8'(commit_q);
        seq_err_d     = err;
        err_sticky_d  = err || (err_sticky_q && !bus.clr_err);
        rd_d          = disp_q[bus.rd_row];
    end
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            stab_q        <= '0;
            to_q          <= '0;
            state_q       <= HUNT;
            exp_row_q     <= '0;
            work_q        <= '{default: '0};
            disp_q        <= '{default: '0};
            commit_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            seq_err_q     <= 1'b0;
            err_sticky_q  <= 1'b0;
            rd_q          <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            stab_q        <= stab_d;
            to_q          <= to_d;
            state_q       <= state_d;
            exp_row_q     <= exp_row_d;
            work_q        <= work_d;
            disp_q        <= disp_d;
            commit_q      <= commit_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            seq_err_q     <= seq_err_d;
            err_sticky_q  <= err_sticky_d;
            rd_q          <= rd_d;
        end
    end
    assign bus.rd_r        = rd_q[23:16];
    assign bus.rd_g        = rd_q[15:8];
    assign bus.rd_b        = rd_q[7:0];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.err_sticky  = err_sticky_q;
    assign bus.stalled     = to_q >= TW'(TIMEOUT);
endmodule

// File: tb/tb_led_scan_capture.sv
// tb_led_scan_capture: directed scan sequences checked against a frame-level model every cycle.
module tb_led_scan_capture;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;
    logic SYS_CLK = 1'b0;
    logic RST = 1'b1;
    led_scan_capture_if bus();
    led_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .SYS_CLK(SYS_CLK),
        .RST(RST),
        .bus(bus)
    );
    always #5 SYS_CLK = ~SYS_CLK;
    int checks = 0;
    int errors = 0;
    int fv_seen = 0;
    int se_seen = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask
    // Model: inputs reach the logic two edges late; a row is taken on the SETTLE-th
    // consecutive edge with an unchanged sample; frames are rows 0..7 in order.
    logic [27:0] h1 = '0, h2 = '0, last = '0;
    int          run = 1;
    logic [23:0] m_work [8];
    logic [23:0] m_disp [8];
    bit          in_frame = 0, pend = 0;
    int          nxt = 0, e_fc = 0, idle = 0;
    logic [23:0] e_rd = '0;
    bit          e_fv = 0, e_err = 0, e_sticky = 0;
    always @(posedge SYS_CLK) begin : model
        logic [27:0] s;
        logic [2:0]  row;
        bit          cap;
        if (RST) begin
            h1 = '0; h2 = '0; last = '0; run = 1;
            for (int i = 0; i < 8; i++) begin m_work[i] = '0; m_disp[i] = '0; end
            in_frame = 0; pend = 0; nxt = 0; e_fc = 0; idle = 0;
            e_rd = '0; e_fv = 0; e_err = 0; e_sticky = 0;
        end else begin
            s = h2; h2 = h1; h1 = {bus.enable, bus.comm, bus.LedR, bus.LedG, bus.LedB};
            run = (s == last) ? run + 1 : 1;
            last = s;
            cap = s[27] && run == SETTLE;
            e_rd = m_disp[bus.rd_row];
            e_fv = pend;
            if (pend) begin
                for (int i = 0; i < 8; i++) m_disp[i] = m_work[i];
                e_fc = (e_fc + 1) % 256;
            end
            pend = 0;
            e_err = 0;
            row = s[26:24];
            if (!s[27]) in_frame = 0;
            else if (cap) begin
                if (in_frame && int'(row) == nxt) begin
                    m_work[row] = ~s[23:0];
                    nxt++;
                    if (row == 3'd7) begin pend = 1; in_frame = 0; end
                end else begin
                    e_err = in_frame;
                    if (row == 3'd0) begin m_work[0] = ~s[23:0]; nxt = 1; in_frame = 1; end
                    else in_frame = 0;
                end
            end
            e_sticky = e_err || (e_sticky && !bus.clr_err);
            idle = cap ? 0 : idle + 1;
        end
    end
    always @(negedge SYS_CLK) begin
        chk("rd_r", 32'(bus.rd_r), 32'(e_rd[23:16]));
        chk("rd_g", 32'(bus.rd_g), 32'(e_rd[15:8]));
        chk("rd_b", 32'(bus.rd_b), 32'(e_rd[7:0]));
        chk("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
        chk("frame_count", 32'(bus.frame_count), 32'(e_fc));
        chk("seq_err", 32'(bus.seq_err), 32'(e_err));
        chk("err_sticky", 32'(bus.err_sticky), 32'(e_sticky));
        chk("stalled", 32'(bus.stalled), 32'(idle >= TIMEOUT));
        fv_seen += int'(bus.frame_valid);
        se_seen += int'(bus.seq_err);
    end
    task automatic tick(int n);
        repeat (n) begin
            @(posedge SYS_CLK);
            #1;
            bus.rd_row = bus.rd_row + 3'd1;
        end
    endtask
    task automatic show(int row, logic [7:0] r, logic [7:0] g, logic [7:0] b, int n);
        bus.comm = 3'(row);
        bus.LedR = r;
        bus.LedG = g;
        bus.LedB = b;
        tick(n);
    endtask
    task automatic rows(int first, int lst, int base, int n);
        for (int k = first; k <= lst; k++) show(k, 8'(~(base + k)), 8'(~(base + 2 * k)), 8'(~(base + 3 * k)), n);
    endtask
    task automatic rd_chk(int row, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        bus.rd_row = 3'(row);
        @(posedge SYS_CLK);
        #1;
        chk($sformatf("lit rd_r row%0d", row), 32'(bus.rd_r), 32'(r));
        chk($sformatf("lit rd_g row%0d", row), 32'(bus.rd_g), 32'(g));
        chk($sformatf("lit rd_b row%0d", row), 32'(bus.rd_b), 32'(b));
    endtask
    initial begin
        int fv0, se0, w;
        bus.comm = 3'd0; bus.enable = 1'b0;
        bus.LedR = 8'hff; bus.LedG = 8'hff; bus.LedB = 8'hff;
        bus.rd_row = 3'd0; bus.clr_err = 1'b0;
        tick(3);
        RST = 1'b0;
        chk("lit reset frame_count", 32'(bus.frame_count), 0);
        tick(50);
        chk("lit idle stalled low", 32'(bus.stalled), 0);
        for (int r = 0; r < 8; r++) rd_chk(r, 8'h00, 8'h00, 8'h00);
        tick(60);
        chk("lit idle stalled high", 32'(bus.stalled), 1);
        // frame 1: blue diagonal
        fv0 = fv_seen;
        bus.enable = 1'b1;
        for (int k = 0; k < 8; k++) show(k, 8'hff, 8'hff, ~(8'd1 << k), 50);
        chk("lit frame1 pulses", 32'(fv_seen - fv0), 1);
        chk("lit frame1 count", 32'(bus.frame_count), 1);
        chk("lit frame1 stalled", 32'(bus.stalled), 0);
        rd_chk(3, 8'h00, 8'h00, 8'h08);
        // frame 2: short data glitch on row 2 must not be taken
        rows(0, 1, 16, 12);
        show(2, 8'h00, 8'hff, 8'hff, 2);
        show(2, 8'(~8'h12), 8'hff, 8'hff, 12);
        rows(3, 7, 16, 12);
        chk("lit glitch count", 32'(bus.frame_count), 2);
        chk("lit glitch no err", 32'(se_seen), 0);
        rd_chk(2, 8'h12, 8'h00, 8'h00);
        // skipped row: 0,1,3
        se0 = se_seen;
        show(0, 8'hf0, 8'h0f, 8'h3c, 12);
        show(1, 8'hf1, 8'h1f, 8'h3d, 12);
        show(3, 8'hf3, 8'h3f, 8'h3f, 12);
        chk("lit skip seq_err", 32'(se_seen - se0), 1);
        chk("lit skip sticky", 32'(bus.err_sticky), 1);
        chk("lit skip no frame", 32'(bus.frame_count), 2);
        rows(0, 7, 32, 12);
        chk("lit after skip count", 32'(bus.frame_count), 3);
        chk("lit sticky holds", 32'(bus.err_sticky), 1);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("lit sticky cleared", 32'(bus.err_sticky), 0);
        // restart: 0,1,0 then 1..7 completes the restarted frame
        rows(0, 1, 48, 12);
        rows(0, 7, 64, 12);
        chk("lit restart count", 32'(bus.frame_count), 4);
        chk("lit restart seq_err", 32'(se_seen - se0), 2);
        rd_chk(5, 8'(64 + 5), 8'(64 + 10), 8'(64 + 15));
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        // enable drop mid-frame discards the partial frame silently
        rows(0, 2, 80, 12);
        bus.enable = 1'b0;
        tick(12);
        bus.enable = 1'b1;
        tick(12);
        rows(3, 7, 80, 12);
        chk("lit enable drop count", 32'(bus.frame_count), 4);
        chk("lit enable drop no err", 32'(bus.err_sticky), 0);
        // stall with comm frozen, then recover on next capture
        tick(110);
        chk("lit stall high", 32'(bus.stalled), 1);
        show(0, 8'h7e, 8'h7e, 8'h7e, 1);
        w = 0;
        while (bus.stalled && w < 20) begin tick(1); w++; end
        chk("lit stall cleared", 32'(bus.stalled), 0);
        tick(12);
        rows(1, 7, 96, 12);
        chk("lit pre-reset count", 32'(bus.frame_count), 5);
        // reset in the middle of the next frame
        rows(0, 4, 112, 12);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("lit mid reset count", 32'(bus.frame_count), 0);
        rd_chk(1, 8'h00, 8'h00, 8'h00);
        rows(5, 7, 112, 12);
        chk("lit tail ignored", 32'(bus.frame_count), 0);
        rows(0, 7, 128, 12);
        chk("lit after reset frame", 32'(bus.frame_count), 1);
        rd_chk(7, 8'(128 + 7), 8'(128 + 14), 8'(128 + 21));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
